// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV64 M-extension sequencer: iterative shift-add multiplier and
// restoring divider with pipeline stall and flush handling.
// Optional feature macro: MULDIV_FAST_MUL_EN (combinational multiplier in PREP).
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_word_op,
  input  logic [XLEN-1:0] srcA_i,
  input  logic [XLEN-1:0] srcB_i,
  input  logic            flushE_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stallE_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]        f3_q;
  logic              word_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_q;
  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   res_q;

  logic            is_div, signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_shift, min_val;
  logic            div_zero, div_ovf, is_special;
  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_diff;
  logic [2*XLEN-1:0] div_next;
`ifndef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] mul_next;
`endif
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_sel, fix_raw, fix_val;

  // Operand conditioning: a_q/b_q hold the raw operands only during PREP,
  // after which they are reused for the shifted multiplier and the divisor.
  always_comb begin
    is_div   = f3_q[2];
    signed_a = is_div ? ~f3_q[0] : ~(f3_q[1] & f3_q[0]);
    signed_b = is_div ? ~f3_q[0] : ~f3_q[1];
    a_ext    = a_q;
    b_ext    = b_q;
    if (word_q) begin
      a_ext = {{(XLEN-32){signed_a & a_q[31]}}, a_q[31:0]};
      b_ext = {{(XLEN-32){signed_b & b_q[31]}}, b_q[31:0]};
    end
    sign_a   = signed_a & a_ext[XLEN-1];
    sign_b   = signed_b & b_ext[XLEN-1];
    a_mag    = sign_a ? -a_ext : a_ext;
    b_mag    = sign_b ? -b_ext : b_ext;
    a_shift  = word_q ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
    min_val  = word_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & ~f3_q[0] & (a_ext == min_val) & (&b_ext);
    is_special = div_zero | div_ovf;
  end

  // One iteration step: restoring divide on {remainder, quotient} and
  // MSB-first shift-add multiply on the product.
  always_comb begin
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    fits     = (rem_sh >= {1'b0, b_q});
    rem_diff = rem_sh[XLEN-1:0] - b_q;
    div_next = {(fits ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], fits};
`ifndef MULDIV_FAST_MUL_EN
    mul_next = {acc_q[2*XLEN-2:0], 1'b0} +
               (a_q[XLEN-1] ? {{XLEN{1'b0}}, b_q} : {(2*XLEN){1'b0}});
`endif
  end

  // Final sign correction, half selection and W-form sign extension.
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    div_sel = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (is_div)
      fix_raw = neg_q ? -div_sel : div_sel;
    else if ((f3_q[1:0] == 2'b00) || word_q)
      fix_raw = prod[XLEN-1:0];
    else
      fix_raw = prod[2*XLEN-1:XLEN];
    fix_val = word_q ? {{(XLEN-32){fix_raw[31]}}, fix_raw[31:0]} : fix_raw;
  end

  // State register; reset forces IDLE from anywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a flush overrides every transition and blocks accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = PREP;
      PREP: begin
`ifdef MULDIV_FAST_MUL_EN
        if (is_special || !is_div) state_d = FIX;
`else
        if (is_special) state_d = FIX;
`endif
        else state_d = CALC;
      end
      CALC: if (count_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flushE_i) state_d = IDLE;
  end

  // Datapath registers: latch on accept, condition in PREP, iterate in CALC,
  // capture the finished result in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q    <= '0;
      word_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !flushE_i) begin
            f3_q   <= funct3_i;
            word_q <= is_word_op;
            a_q    <= srcA_i;
            b_q    <= srcB_i;
          end
        end
        PREP: begin
          count_q <= word_q ? CW'(32) : CW'(XLEN);
          b_q     <= b_mag;
          neg_q   <= (is_div && f3_q[1]) ? sign_a : (sign_a ^ sign_b);
          if (div_zero) begin
            neg_q <= 1'b0;
            acc_q <= {a_ext, {XLEN{1'b1}}};
          end else if (div_ovf) begin
            neg_q <= 1'b0;
            acc_q <= {{XLEN{1'b0}}, a_ext};
          end else if (is_div) begin
            acc_q <= {{XLEN{1'b0}}, a_shift};
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_q <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
            acc_q <= '0;
            a_q   <= a_shift;
`endif
          end
        end
        CALC: begin
          count_q <= count_q - CW'(1);
`ifdef MULDIV_FAST_MUL_EN
          acc_q <= div_next;
`else
          if (is_div) begin
            acc_q <= div_next;
          end else begin
            acc_q <= mul_next;
            a_q   <= {a_q[XLEN-2:0], 1'b0};
          end
`endif
        end
        FIX: res_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign done_o   = (state_q == DONE) & ~flushE_i;
  assign result_o = done_o ? res_q : '0;
  assign busy_o   = (state_q != IDLE);
  assign stallE_o = start_i & ~done_o;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors with hand-computed
// results and done-edge latencies; a monitor pops and compares on done_o.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML64 = 2;
  localparam int MLW  = 2;
`else
  localparam int ML64 = 66;
  localparam int MLW  = 34;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic        is_word_op;
  logic [63:0] srcA_i;
  logic [63:0] srcB_i;
  logic        flushE_i;
  logic [63:0] result_o;
  logic        done_o;
  logic        busy_o;
  logic        stallE_o;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
    .is_word_op(is_word_op), .srcA_i(srcA_i), .srcB_i(srcB_i),
    .flushE_i(flushE_i), .result_o(result_o), .done_o(done_o),
    .busy_o(busy_o), .stallE_o(stallE_o)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   prev_done  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: actual result %h required no done", result_o);
      end else begin
        e = sb.pop_front();
        checkOutput(e.name, result_o, e.res);
        checkOutput({e.name, "_done_edge"}, 64'(edge_cnt), 64'(e.at));
      end
    end
  end

  // Issue one op, wait for done, check stall behaviour and optional back-to-back accept.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic w,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] res, input int lat, input bit chk_b2b);
    int  acc_edge;
    bit  seen;
    bit  stall_ok;
    @(negedge clk);
    start_i = 1'b1; funct3_i = f3; is_word_op = w; srcA_i = a; srcB_i = b;
    @(posedge clk);
    acc_edge = edge_cnt;
    sb.push_back('{res, acc_edge + lat + 1, name});
    if (chk_b2b) checkOutput({name, "_b2b_accept"}, 64'(acc_edge), 64'(prev_done + 1));
    seen = 1'b0;
    stall_ok = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        prev_done = edge_cnt;
      end else if (stallE_o !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: actual no done required done", name);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      checkOutput({name, "_stall_busy"}, 64'(stall_ok), 64'd1);
      checkOutput({name, "_stall_done"}, 64'(stallE_o), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b1; funct3_i = 3'd0; is_word_op = 1'b0;
    srcA_i = '0; srcB_i = '0; flushE_i = 1'b0;
    #12;
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_result", result_o, 64'd0);
    checkOutput("rst_stall_hi", 64'(stallE_o), 64'd1);
    start_i = 1'b0;
    #1;
    checkOutput("rst_stall_lo", 64'(stallE_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus("mul_7_x_m3",   3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, ML64, 1'b0);
    applyStimulus("div_m20_6",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1);
    applyStimulus("rem_m20_6",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b1);
    applyStimulus("rem_20_m6",    3'd6, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 66, 1'b1);
    applyStimulus("div_20_m6",    3'd4, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1);
    applyStimulus("divw_ovf",     3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, 1'b1);
    applyStimulus("div_ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2, 1'b1);
    applyStimulus("rem_ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, 1'b1);
    applyStimulus("divu_by0",     3'd5, 1'b0, 64'h55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1);
    applyStimulus("remu_by0",     3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 2, 1'b1);
    applyStimulus("rem_by0",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 2, 1'b1);
    applyStimulus("mulhu_max",    3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, ML64, 1'b1);
    applyStimulus("divu_100_7",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b1);
    applyStimulus("mulh_min2",    3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, ML64, 1'b1);
    applyStimulus("mulhsu_m1_2",  3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ML64, 1'b1);
    applyStimulus("mulhu_m1_2",   3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, ML64, 1'b1);
    applyStimulus("mulw",         3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MLW, 1'b1);
    applyStimulus("remuw",        3'd7, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'h0000_0001_0000_0003, 64'd1, 34, 1'b1);
    applyStimulus("divw_m20_6",   3'd4, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b1);
    applyStimulus("divuw",        3'd5, 1'b1, 64'h8000_0000, 64'd2, 64'h4000_0000, 34, 1'b1);
    applyStimulus("remw_by0",     3'd6, 1'b1, 64'hABCD_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2, 1'b1);

    // Flush a DIV: raised after edge 10, sampled at edge 11.
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; is_word_op = 1'b0;
    srcA_i = 64'hFFFF_FFFF_FFFF_FFEC; srcB_i = 64'd6;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("flush_busy_before", 64'(busy_o), 64'd1);
    flushE_i = 1'b1;
    @(negedge clk);
    flushE_i = 1'b0;
    start_i = 1'b0;
    checkOutput("flush_busy_after", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    applyStimulus("mul_2x3", 3'd0, 1'b0, 64'd2, 64'd3, 64'd6, ML64, 1'b0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; is_word_op = 1'b0; srcA_i = 64'd100; srcB_i = 64'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_busy", 64'(busy_o), 64'd0);
    checkOutput("arst_done", 64'(done_o), 64'd0);
    checkOutput("arst_result", result_o, 64'd0);
    checkOutput("arst_stall", 64'(stallE_o), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus("divu_after_rst", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b0);

    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
